err_corrector_s3: RTL and testbench
===================================

ERR_CORRECTOR_S3 -- requirements
Module: err_corrector_s3

Interface
REQ-001 SHALL have parameter W, default 10, meaning GF(2^W) symbol width.
REQ-002 SHALL have parameter T, default 11, meaning max correctable symbols per codeword.
REQ-003 SHALL have parameter n, default 544, meaning codeword length in symbols.
REQ-004 SHALL have localparam POS_W = $clog2(1023), meaning position width, and CNT_W = $clog2(T+2).
REQ-005 SHALL have ports: clk_i  in  1  single clock, all logic posedge; rst_i  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: flush_i in 1 sync abort; fy_vld_i in 1 Forney event valid; fy_pos_i in POS_W error position; fy_y_i in W error magnitude; fy_den_zero_i in 1 Forney denominator zero; fy_rdy_o out 1 event accept.
REQ-007 SHALL have ports: deg_vld_i in 1 sigma degree strobe; deg_i in CNT_W deg(sigma); chien_done_i in 1 Chien scan complete pulse.
REQ-008 SHALL have ports: rx_vld_i in 1; rx_sym_i in W; rx_rdy_o out 1 (received stream, highest-degree symbol first).
REQ-009 SHALL have ports: cw_vld_o out 1; cw_sym_o out W; cw_last_o out 1; cw_rdy_i in 1 (corrected stream).
REQ-010 SHALL have ports: dec_done_o out 1 one-cycle end pulse; dec_fail_o out 1 held until next codeword; err_cnt_o out CNT_W corrections applied.

Function
REQ-011 SHALL implement FSM IDLE, COLLECT, CORRECT; IDLE->COLLECT on deg_vld_i (deg_i latched).
REQ-012 In COLLECT, fy_rdy_o SHALL be 1; each fy_vld_i event SHALL be written to table entry err_cnt and err_cnt SHALL increment.
REQ-013 fy_rdy_o SHALL be 0 in IDLE and CORRECT.
REQ-014 Fail flag SHALL set on: event with fy_den_zero_i; fy_pos_i >= n; fy_pos_i equal to a stored position; event when err_cnt == T (event discarded, err_cnt saturates at T).
REQ-015 COLLECT->CORRECT on chien_done_i; an event in the same cycle SHALL be accepted and counted first; fail SHALL also set if final count != latched deg.
REQ-016 In CORRECT, a down-counter SHALL load n-1 and track position of each accepted rx symbol; rx_rdy_o = (state==CORRECT) & (~cw_vld_o | cw_rdy_i).
REQ-017 Each accepted symbol SHALL be registered to cw_sym_o with 1-cycle latency, XORed with stored y whose position equals counter, unless fail set (pass-through).
REQ-018 cw_vld_o/cw_sym_o/cw_last_o SHALL hold stable while cw_vld_o & ~cw_rdy_i.
REQ-019 cw_last_o SHALL assert with the symbol at position 0; on its transfer FSM SHALL return to IDLE, pulse dec_done_o, clear table valid bits.
REQ-020 err_cnt_o SHALL show entries count, 0 when fail set, updated at dec_done_o.
REQ-021 deg_vld_i outside IDLE SHALL be ignored; rx_vld_i outside CORRECT SHALL not be accepted.
REQ-022 flush_i SHALL in the same cycle force IDLE, clear table, counters, cw_vld_o; outputs otherwise as reset except dec_fail_o unchanged.

Reset
REQ-023 rst_i SHALL asynchronously force IDLE, table invalid, counters 0, and all outputs 0.
REQ-024 Reset mid-stream SHALL drop the partial codeword; no cw_last_o or dec_done_o emitted afterwards for it.

Configuration
REQ-025 With macro ERR_CORRECTOR_STATS_EN defined, module SHALL add outputs stat_ok_o[31:0] and stat_fail_o[31:0], incrementing at dec_done_o per outcome, saturating, cleared by rst_i only.
REQ-026 Without ERR_CORRECTOR_STATS_EN, those ports and counters SHALL not exist.

Verification
REQ-027 deg=2, events (pos 543,y 0x001),(pos 0,y 0x3FF), done; rx all 0x155 -> first symbol 0x154, last 0x2AA with cw_last_o, err_cnt_o=2, dec_fail_o=0.
REQ-028 deg=3, two events then done -> stream unmodified, dec_fail_o=1, err_cnt_o=0.
REQ-029 12 events with T=11 -> 12th discarded, fail=1, fy_rdy_o stays 1 in COLLECT.
REQ-030 cw_rdy_i toggled 50% random over 544 symbols -> no drop/duplicate, exactly one cw_last_o, output held during stall.
REQ-031 Event with fy_den_zero_i=1 simultaneous with chien_done_i -> counted, fail=1, FSM enters CORRECT next cycle.
REQ-032 rst_i asserted at symbol 200 -> all outputs 0 immediately; next codeword corrected normally.

Source files
------------

// File: rtl/err_corrector_s3_if.sv
// Bus bundle for err_corrector_s3: Forney events, sigma degree, received and corrected streams.
// The slave modport is the corrector's view; the master modport is the surrounding decoder's view.
interface err_corrector_s3_if #(
    parameter int W     = 10,
    parameter int POS_W = 10,
    parameter int CNT_W = 4
);
    logic             flush_i;
    logic             fy_vld_i;
    logic [POS_W-1:0] fy_pos_i;
    logic [W-1:0]     fy_y_i;
    logic             fy_den_zero_i;
    logic             fy_rdy_o;
    logic             deg_vld_i;
    logic [CNT_W-1:0] deg_i;
    logic             chien_done_i;
    logic             rx_vld_i;
    logic [W-1:0]     rx_sym_i;
    logic             rx_rdy_o;
    logic             cw_vld_o;
    logic [W-1:0]     cw_sym_o;
    logic             cw_last_o;
    logic             cw_rdy_i;
    logic             dec_done_o;
    logic             dec_fail_o;
    logic [CNT_W-1:0] err_cnt_o;

    modport slave (
        input  flush_i, fy_vld_i, fy_pos_i, fy_y_i, fy_den_zero_i,
        input  deg_vld_i, deg_i, chien_done_i,
        input  rx_vld_i, rx_sym_i, cw_rdy_i,
        output fy_rdy_o, rx_rdy_o, cw_vld_o, cw_sym_o, cw_last_o,
        output dec_done_o, dec_fail_o, err_cnt_o
    );

    modport master (
        output flush_i, fy_vld_i, fy_pos_i, fy_y_i, fy_den_zero_i,
        output deg_vld_i, deg_i, chien_done_i,
        output rx_vld_i, rx_sym_i, cw_rdy_i,
        input  fy_rdy_o, rx_rdy_o, cw_vld_o, cw_sym_o, cw_last_o,
        input  dec_done_o, dec_fail_o, err_cnt_o
    );
endinterface

// File: rtl/err_corrector_s3.sv
// RS error corrector: collects Forney (position, magnitude) events, then XORs them into the received stream.
// Optional macro ERR_CORRECTOR_STATS_EN adds saturating ok/fail codeword counters.
module err_corrector_s3 #(
    parameter int W = 10,
    parameter int T = 11,
    parameter int n = 544
) (
    input  logic clk_i,
    input  logic rst_i,
    err_corrector_s3_if.slave bus
`ifdef ERR_CORRECTOR_STATS_EN
    ,
    output logic [31:0] stat_ok_o,
    output logic [31:0] stat_fail_o
`endif
);
    localparam int POS_W = $clog2(1023);
    localparam int CNT_W = $clog2(T + 2);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] CORRECT = 2'd2;

    logic [1:0]       state;
    logic [POS_W-1:0] tbl_pos [T];
    logic [W-1:0]     tbl_y   [T];
    logic [T-1:0]     tbl_vld;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] deg_q;
    logic             fail_q;
    logic [POS_W-1:0] pos_cnt;
    logic             rx_done;

    logic             vld_p1;
    logic [W-1:0]     sym_p1;
    logic             last_p1;
    logic             dec_done_q;
    logic [CNT_W-1:0] err_cnt_out_q;

    logic             ev_acc;
    logic             ev_full;
    logic             ev_dup;
    logic             ev_pos_bad;
    logic             ev_store;
    logic             ev_fail;
    logic [CNT_W-1:0] cnt_next;
    logic [W-1:0]     corr;
    logic             rx_acc;
    logic             rx_rdy;
    logic             last_xfer;

    // Event qualification against the table built so far.
    always_comb begin
        ev_dup = 1'b0;
        for (int i = 0; i < T; i++) begin
            if (tbl_vld[i] && (tbl_pos[i] == bus.fy_pos_i)) ev_dup = 1'b1;
        end
    end

    assign ev_acc     = bus.fy_vld_i & (state == COLLECT);
    assign ev_full    = (err_cnt == CNT_W'(T));
    assign ev_pos_bad = (int'(bus.fy_pos_i) >= n);
    assign ev_store   = ev_acc & ~ev_full;
    assign ev_fail    = ev_acc & (bus.fy_den_zero_i | ev_pos_bad | ev_dup | ev_full);
    assign cnt_next   = err_cnt + CNT_W'(ev_store);

    // Magnitude lookup for the symbol currently at the head of the received stream.
    always_comb begin
        corr = '0;
        for (int i = 0; i < T; i++) begin
            if (tbl_vld[i] && (tbl_pos[i] == pos_cnt)) corr = corr ^ tbl_y[i];
        end
    end

    // rx_done stops intake after position 0 so nothing leaks past the final symbol.
    assign rx_rdy    = (state == CORRECT) & ~rx_done & (~vld_p1 | bus.cw_rdy_i);
    assign rx_acc    = bus.rx_vld_i & rx_rdy;
    assign last_xfer = vld_p1 & last_p1 & bus.cw_rdy_i;

    always_ff @(posedge clk_i) begin
        if (ev_store) begin
            tbl_pos[err_cnt] <= bus.fy_pos_i;
            tbl_y[err_cnt]   <= bus.fy_y_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            tbl_vld       <= '0;
            err_cnt       <= '0;
            deg_q         <= '0;
            fail_q        <= 1'b0;
            pos_cnt       <= '0;
            rx_done       <= 1'b0;
            vld_p1        <= 1'b0;
            sym_p1        <= '0;
            last_p1       <= 1'b0;
            dec_done_q    <= 1'b0;
            err_cnt_out_q <= '0;
        end else if (bus.flush_i) begin
            state         <= IDLE;
            tbl_vld       <= '0;
            err_cnt       <= '0;
            deg_q         <= '0;
            pos_cnt       <= '0;
            rx_done       <= 1'b0;
            vld_p1        <= 1'b0;
            sym_p1        <= '0;
            last_p1       <= 1'b0;
            dec_done_q    <= 1'b0;
            err_cnt_out_q <= '0;
        end else begin
            dec_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.deg_vld_i) begin
                        deg_q   <= bus.deg_i;
                        err_cnt <= '0;
                        fail_q  <= 1'b0;
                        tbl_vld <= '0;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (ev_store) begin
                        tbl_vld[err_cnt] <= 1'b1;
                        err_cnt          <= cnt_next;
                    end
                    if (ev_fail) fail_q <= 1'b1;
                    if (bus.chien_done_i) begin
                        if (cnt_next != deg_q) fail_q <= 1'b1;
                        pos_cnt <= POS_W'(n - 1);
                        rx_done <= 1'b0;
                        state   <= CORRECT;
                    end
                end
                CORRECT: begin
                    // Output stage p1: one register between rx acceptance and cw presentation.
                    if (rx_acc) begin
                        vld_p1  <= 1'b1;
                        sym_p1  <= bus.rx_sym_i ^ (fail_q ? '0 : corr);
                        last_p1 <= (pos_cnt == '0);
                        if (pos_cnt == '0) rx_done <= 1'b1;
                        else               pos_cnt <= pos_cnt - POS_W'(1);
                    end else if (bus.cw_rdy_i) begin
                        vld_p1  <= 1'b0;
                        last_p1 <= 1'b0;
                    end
                    if (last_xfer) begin
                        state         <= IDLE;
                        dec_done_q    <= 1'b1;
                        tbl_vld       <= '0;
                        err_cnt       <= '0;
                        err_cnt_out_q <= fail_q ? '0 : err_cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fy_rdy_o   = (state == COLLECT);
    assign bus.rx_rdy_o   = rx_rdy;
    assign bus.cw_vld_o   = vld_p1;
    assign bus.cw_sym_o   = sym_p1;
    assign bus.cw_last_o  = last_p1;
    assign bus.dec_done_o = dec_done_q;
    assign bus.dec_fail_o = fail_q;
    assign bus.err_cnt_o  = err_cnt_out_q;

`ifdef ERR_CORRECTOR_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Only the async reset clears the statistics; flush leaves them alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_ok_o   <= '0;
            stat_fail_o <= '0;
        end else if (dec_done_q) begin
            if (fail_q) stat_fail_o <= sat_inc(stat_fail_o);
            else        stat_ok_o   <= sat_inc(stat_ok_o);
        end
    end
`endif
endmodule

// File: tb/tb_err_corrector_s3.sv
// Table-driven bench for err_corrector_s3 with a scoreboard queue on the corrected stream.
module tb_err_corrector_s3;
    localparam int W = 10, T = 11, N = 544, POS_W = 10, CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    err_corrector_s3_if #(.W(W), .POS_W(POS_W), .CNT_W(CNT_W)) bus ();

`ifdef ERR_CORRECTOR_STATS_EN
    logic [31:0] stat_ok, stat_fail;
`endif

    err_corrector_s3 #(.W(W), .T(T), .n(N)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
`ifdef ERR_CORRECTOR_STATS_EN
        ,
        .stat_ok_o  (stat_ok),
        .stat_fail_o(stat_fail)
`endif
    );

    typedef struct packed {
        logic [CNT_W-1:0]       deg;
        logic [4:0]             nev;
        logic [11:0][POS_W-1:0] pos;
        logic [11:0][W-1:0]     y;
        logic [11:0]            dz;
        logic                   with_done;
        logic                   const_rx;
        logic [W-1:0]           rx_val;
        logic                   rand_rdy;
        logic                   exp_fail;
        logic [CNT_W-1:0]       exp_cnt;
    } case_t;

    typedef struct packed {
        logic [W-1:0] sym;
        logic         last;
    } exp_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    lasts = 0;
    logic  rand_rdy = 1'b0;
    exp_t  q[$];
    case_t cs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] corr_of(input case_t c, input int p);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(c.nev) && i < T; i++)
            if (int'(c.pos[i]) == p) r = r ^ c.y[i];
        return r;
    endfunction

    initial begin : rdy_drv
        forever begin
            @(posedge clk);
            #1;
            bus.cw_rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        logic         held;
        logic [W-1:0] hsym;
        logic         hlast;
        exp_t         e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("stall_vld",  32'(bus.cw_vld_o),  32'd1);
                    check("stall_sym",  32'(bus.cw_sym_o),  32'(hsym));
                    check("stall_last", 32'(bus.cw_last_o), 32'(hlast));
                end
                held = 1'b0;
                if (bus.cw_vld_o && bus.cw_rdy_i) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL cw_extra: got 0x%0h required no symbol", bus.cw_sym_o);
                    end else begin
                        e = q.pop_front();
                        check("cw_sym",  32'(bus.cw_sym_o),  32'(e.sym));
                        check("cw_last", 32'(bus.cw_last_o), 32'(e.last));
                    end
                    if (bus.cw_last_o) lasts++;
                end else if (bus.cw_vld_o) begin
                    held  = 1'b1;
                    hsym  = bus.cw_sym_o;
                    hlast = bus.cw_last_o;
                end
            end
        end
    end

    task automatic run_case(input case_t c, input int abort_at);
        int           acc;
        int           budget;
        int           lasts0;
        logic [W-1:0] s;
        exp_t         e;
        lasts0 = lasts;
        @(posedge clk); #1;
        bus.deg_vld_i = 1'b1;
        bus.deg_i     = c.deg;
        @(posedge clk); #1;
        bus.deg_vld_i = 1'b0;
        for (int i = 0; i < int'(c.nev); i++) begin
            bus.fy_vld_i      = 1'b1;
            bus.fy_pos_i      = c.pos[i];
            bus.fy_y_i        = c.y[i];
            bus.fy_den_zero_i = c.dz[i];
            bus.chien_done_i  = c.with_done && (i == int'(c.nev) - 1);
            @(negedge clk);
            check("fy_rdy_collect", 32'(bus.fy_rdy_o), 32'd1);
            @(posedge clk); #1;
        end
        bus.fy_vld_i      = 1'b0;
        bus.fy_den_zero_i = 1'b0;
        if (!(c.with_done && c.nev != 0)) begin
            bus.chien_done_i = 1'b1;
            @(posedge clk); #1;
        end
        bus.chien_done_i = 1'b0;
        @(negedge clk);
        check("correct_rx_rdy", 32'(bus.rx_rdy_o), 32'd1);
        check("correct_fy_rdy", 32'(bus.fy_rdy_o), 32'd0);

        rand_rdy = c.rand_rdy;
        acc      = 0;
        budget   = 0;
        @(posedge clk); #1;
        while (acc < N) begin
            s = c.const_rx ? c.rx_val : W'($urandom);
            bus.rx_vld_i = 1'b1;
            bus.rx_sym_i = s;
            @(negedge clk);
            if (bus.rx_rdy_o) begin
                e.sym  = c.exp_fail ? s : s ^ corr_of(c, N - 1 - acc);
                e.last = (acc == N - 1);
                q.push_back(e);
                acc++;
            end
            @(posedge clk); #1;
            budget++;
            if (budget > 20 * N) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_timeout: got %0d accepted required %0d", acc, N);
                break;
            end
            if (abort_at >= 0 && acc == abort_at) begin
                bus.rx_vld_i = 1'b0;
                return;
            end
        end
        bus.rx_vld_i = 1'b0;

        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!bus.dec_done_o && budget < 4000);
        rand_rdy = 1'b0;
        check("dec_done",   32'(bus.dec_done_o), 32'd1);
        check("dec_fail",   32'(bus.dec_fail_o), 32'(c.exp_fail));
        check("err_cnt",    32'(bus.err_cnt_o),  32'(c.exp_cnt));
        check("queue_left", 32'(q.size()),       32'd0);
        check("last_count", 32'(lasts - lasts0), 32'd1);
        @(negedge clk);
        check("dec_done_pulse", 32'(bus.dec_done_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cw_vld"},   32'(bus.cw_vld_o),   32'd0);
        check({tag, "_cw_sym"},   32'(bus.cw_sym_o),   32'd0);
        check({tag, "_cw_last"},  32'(bus.cw_last_o),  32'd0);
        check({tag, "_dec_done"}, 32'(bus.dec_done_o), 32'd0);
        check({tag, "_dec_fail"}, 32'(bus.dec_fail_o), 32'd0);
        check({tag, "_err_cnt"},  32'(bus.err_cnt_o),  32'd0);
        check({tag, "_fy_rdy"},   32'(bus.fy_rdy_o),   32'd0);
        check({tag, "_rx_rdy"},   32'(bus.rx_rdy_o),   32'd0);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lasts0;
        int saw_done;
        bus.flush_i = 1'b0;       bus.fy_vld_i = 1'b0;     bus.fy_pos_i = '0;
        bus.fy_y_i = '0;          bus.fy_den_zero_i = 1'b0; bus.deg_vld_i = 1'b0;
        bus.deg_i = '0;           bus.chien_done_i = 1'b0;  bus.rx_vld_i = 1'b0;
        bus.rx_sym_i = '0;        bus.cw_rdy_i = 1'b1;

        for (int k = 0; k < 9; k++) cs[k] = '0;
        cs[0].deg = 2; cs[0].nev = 2;
        cs[0].pos[0] = 10'd543; cs[0].y[0] = 10'h001;
        cs[0].pos[1] = 10'd0;   cs[0].y[1] = 10'h3FF;
        cs[0].const_rx = 1'b1;  cs[0].rx_val = 10'h155; cs[0].exp_cnt = 2;
        cs[1].deg = 3; cs[1].nev = 2;
        cs[1].pos[0] = 10'd10;  cs[1].y[0] = 10'h005;
        cs[1].pos[1] = 10'd20;  cs[1].y[1] = 10'h006;
        cs[1].exp_fail = 1'b1;
        cs[2].deg = 11; cs[2].nev = 12; cs[2].exp_fail = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cs[2].pos[i] = 10'(i * 40 + 3);
            cs[2].y[i]   = 10'(i + 1);
        end
        cs[3].deg = 1; cs[3].nev = 1; cs[3].pos[0] = 10'd100; cs[3].y[0] = 10'h0AA;
        cs[3].dz[0] = 1'b1; cs[3].with_done = 1'b1; cs[3].exp_fail = 1'b1;
        cs[4].deg = 2; cs[4].nev = 2; cs[4].exp_fail = 1'b1;
        cs[4].pos[0] = 10'd50; cs[4].y[0] = 10'h011;
        cs[4].pos[1] = 10'd50; cs[4].y[1] = 10'h022;
        cs[5].deg = 1; cs[5].nev = 1; cs[5].pos[0] = 10'd544; cs[5].y[0] = 10'h033;
        cs[5].exp_fail = 1'b1;
        cs[6].deg = 0; cs[6].nev = 0;
        cs[7].deg = 5; cs[7].nev = 5; cs[7].with_done = 1'b1; cs[7].rand_rdy = 1'b1;
        cs[7].pos[0] = 10'd543; cs[7].pos[1] = 10'd300; cs[7].pos[2] = 10'd271;
        cs[7].pos[3] = 10'd1;   cs[7].pos[4] = 10'd0;   cs[7].exp_cnt = 5;
        for (int i = 0; i < 5; i++) cs[7].y[i] = 10'($urandom_range(1, 1023));
        cs[8].deg = 11; cs[8].nev = 11; cs[8].rand_rdy = 1'b1; cs[8].exp_cnt = 11;
        for (int i = 0; i < 11; i++) begin
            cs[8].pos[i] = 10'(i * 49);
            cs[8].y[i]   = 10'(10'h3FF - i);
        end

        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 9; k++) run_case(cs[k], -1);

        // Flush mid-collection: back to idle, fail flag left as it was.
        @(posedge clk); #1;
        bus.deg_vld_i = 1'b1; bus.deg_i = 4'd2;
        @(posedge clk); #1;
        bus.deg_vld_i = 1'b0;
        bus.fy_vld_i = 1'b1; bus.fy_pos_i = 10'd7; bus.fy_y_i = 10'h001; bus.fy_den_zero_i = 1'b1;
        @(posedge clk); #1;
        bus.fy_vld_i = 1'b0; bus.fy_den_zero_i = 1'b0;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_fy_rdy",   32'(bus.fy_rdy_o),   32'd0);
        check("flush_dec_fail", 32'(bus.dec_fail_o), 32'd1);
        check("flush_err_cnt",  32'(bus.err_cnt_o),  32'd0);
        check("flush_cw_vld",   32'(bus.cw_vld_o),   32'd0);

        // Async reset at symbol 200, then a clean codeword.
        lasts0 = lasts;
        run_case(cs[0], 200);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.dec_done_o || bus.cw_vld_o) saw_done++;
        end
        check("midrst_no_tail", 32'(saw_done),        32'd0);
        check("midrst_no_last", 32'(lasts - lasts0), 32'd0);
        run_case(cs[0], -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
